noc_switch_arbiter: RTL and testbench
=====================================

# noc_switch_arbiter

Routing and arbitration core for one node of the unidirectional 2-D torus NoC. It has three input ports (left, bottom, local PE) and three output ports (right, top, local PE). Each input flit gets a dimension-ordered XY route. For each output, a round-robin arbiter picks one contender per cycle and loads it into that output's one-entry register. The block is the sequencing and sharing logic inside each mesh node and connects directly to the neighbour links and the PE interface of the mesh top.

## Interface
Parameters:
- x_coord, 0, X coordinate of this node
- y_coord, 0, Y coordinate of this node
- X, 4, mesh columns
- Y, 4, mesh rows
- data_width, 256, payload bits
- x_size, 2, destination-X field width
- y_size, 2, destination-Y field width
- total_width, x_size+y_size+data_width, flit width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are clk and rstn.
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_valid_l / i_valid_b / i_valid_pe  in  1 each  input flit valid (left, bottom, PE)
- i_data_l / i_data_b / i_data_pe  in  total_width each  input flit
- o_ready_l / o_ready_b / o_ready_pe  out  1 each  input flit accepted this cycle
- o_valid_r / o_valid_t / o_valid_pe  out  1 each  output register valid
- o_data_r / o_data_t / o_data_pe  out  total_width each  output register data
- i_ready_r / i_ready_t / i_ready_pe  in  1 each  downstream accepts (PE sink tied 1 at mesh top)

## Operation
- Flit header fields:
  - dest_x = data[x_size-1:0]
  - dest_y = data[x_size+y_size-1:x_size]
  - The payload is carried unmodified.
- Route per valid input, combinational:
  - dest_x != x_coord → right
  - else dest_y != y_coord → top
  - else → pe
- Each input requests exactly one output, so at most one grant per input per cycle. The three outputs arbitrate independently and may grant three different inputs in the same cycle.
- An output is free when !o_valid || i_ready.
- Per-output arbitration:
  - Index order: l=0, b=1, pe=2.
  - The 2-bit round-robin pointer ptr (0..2) selects the highest-priority index. Search order is ptr, ptr+1, ptr+2, all mod 3.
  - Grant only when the output is free and at least one input requests it.
- On a grant to input k:
  - The output register loads that input's flit and o_valid is set.
  - ptr becomes (k+1) mod 3.
  - o_ready_k is asserted in the same cycle.
- No grant:
  - If i_ready && o_valid, o_valid clears.
  - ptr does not change.
- o_ready_* is combinational from valids, routes, pointers and output state. No combinational path exists from i_ready to o_valid/o_data.
- Fairness: an input that is continuously valid toward one output is granted within 3 grants of that output.
- Pointer state values of 3 are unreachable. If reached, treat as 0.

## Timing
- Reset (rstn low, async): all o_valid = 0, o_data = 0, all ptr = 0.
  - o_ready_* = 0 because no grant can occur with valids sampled in reset.
  - Reset asserted mid-transfer drops the held flits with no recovery.
- Latency: input accepted at edge n appears on the output from edge n+1 (1 cycle). Throughput is 1 flit/cycle per output.
- Handshake: a transfer occurs when valid && ready at the rising edge.
  - Outputs hold o_data stable while o_valid && !i_ready.
  - Upstream holds data while valid && !ready.
- Simultaneous drain and load: if o_valid && i_ready and a new grant occurs, the register reloads and o_valid stays 1 (no bubble).
- Full output (o_valid && !i_ready): no grant, all requesters see ready = 0, ptr is held.
- Wrap-around is handled by the mesh wiring. The node compares coordinates only; there is no modular arithmetic here.

## Test plan
- X=Y=4, node (1,2), flit on i_valid_pe with dest (3,2) → o_ready_pe=1 that cycle; next cycle o_valid_r=1, o_data_r equals the input flit; o_valid_t=o_valid_pe=0.
- Three simultaneous flits to the local node (dest (1,2)) from l, b, pe, held valid, i_ready_pe=1 → grant order l, b, pe on consecutive cycles; o_valid_pe high for 3 consecutive cycles.
- i_ready_r=0 with o_valid_r=1, new left flit to the right → o_ready_l=0, o_data_r unchanged for 5 cycles; raise i_ready_r → new flit accepted that cycle and appears with no bubble.
- Parallel routing: l→pe (dest (1,2)), b→r (dest (0,0)), pe→t (dest (1,3)) in one cycle → all three o_ready high; next cycle all three outputs valid with the correct data.
- Starvation check: l and pe continuously request right for 20 cycles, b idle → grants alternate l, pe, l, pe; neither waits more than 1 extra cycle.
- rstn asserted while all outputs are valid and stalled → all o_valid and o_data clear immediately (async); after release the first contender for each output is chosen from ptr=0.

Source files
------------

// File: rtl/noc_switch_arbiter_if.sv
// Handshake bundle between one NoC node switch and its neighbours / PE.
// Input side: left, bottom, PE. Output side: right, top, PE.
interface noc_switch_arbiter_if #(
    parameter int total_width = 260
);
    logic                   i_valid_l;
    logic                   i_valid_b;
    logic                   i_valid_pe;
    logic [total_width-1:0] i_data_l;
    logic [total_width-1:0] i_data_b;
    logic [total_width-1:0] i_data_pe;
    logic                   o_ready_l;
    logic                   o_ready_b;
    logic                   o_ready_pe;
    logic                   o_valid_r;
    logic                   o_valid_t;
    logic                   o_valid_pe;
    logic [total_width-1:0] o_data_r;
    logic [total_width-1:0] o_data_t;
    logic [total_width-1:0] o_data_pe;
    logic                   i_ready_r;
    logic                   i_ready_t;
    logic                   i_ready_pe;

    // Switch side
    modport slave (
        input  i_valid_l, i_valid_b, i_valid_pe,
        input  i_data_l, i_data_b, i_data_pe,
        output o_ready_l, o_ready_b, o_ready_pe,
        output o_valid_r, o_valid_t, o_valid_pe,
        output o_data_r, o_data_t, o_data_pe,
        input  i_ready_r, i_ready_t, i_ready_pe
    );

    // Neighbour / PE side
    modport master (
        output i_valid_l, i_valid_b, i_valid_pe,
        output i_data_l, i_data_b, i_data_pe,
        input  o_ready_l, o_ready_b, o_ready_pe,
        input  o_valid_r, o_valid_t, o_valid_pe,
        input  o_data_r, o_data_t, o_data_pe,
        output i_ready_r, i_ready_t, i_ready_pe
    );
endinterface

// File: rtl/noc_switch_arbiter.sv
// XY routing and per-output round-robin arbitration for one torus node.
// Index order everywhere: inputs l=0, b=1, pe=2; outputs r=0, t=1, pe=2.
// Each output owns a one-entry register; accepted flits appear one cycle later.
module noc_switch_arbiter #(
    parameter int x_coord     = 0,
    parameter int y_coord     = 0,
    parameter int X           = 4,
    parameter int Y           = 4,
    parameter int data_width  = 256,
    parameter int x_size      = 2,
    parameter int y_size      = 2,
    parameter int total_width = x_size + y_size + data_width
) (
    input  logic                 clk,
    input  logic                 rstn,
    noc_switch_arbiter_if.slave  bus
);

    // Coordinates outside the mesh clamp to the last column/row.
    localparam int LP_XC = (x_coord < X) ? x_coord : X - 1;
    localparam int LP_YC = (y_coord < Y) ? y_coord : Y - 1;
    localparam logic [x_size-1:0] LP_X = LP_XC[x_size-1:0];
    localparam logic [y_size-1:0] LP_Y = LP_YC[y_size-1:0];

    logic [2:0][total_width-1:0] w_in_data;
    logic [2:0]                  w_in_valid;
    logic [2:0]                  w_in_ready;
    logic [2:0]                  w_out_ready;
    logic [2:0][2:0]             w_req;        // [output][input]
    logic [2:0][2:0]             w_gnt;        // [output][input], one-hot per output
    logic [2:0]                  w_free;
    logic [2:0][total_width-1:0] w_load_data;
    logic [2:0][1:0]             w_ptr_nxt;

    logic [2:0]                  r_valid;
    logic [2:0][total_width-1:0] r_data;
    logic [2:0][1:0]             r_ptr;

    // Round-robin pick: search from ptr upward mod 3; a pointer of 3 acts as 0.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] gnt;
        logic       found;
        int         idx;
        gnt   = '0;
        found = 1'b0;
        idx   = (ptr == 2'd3) ? 0 : int'(ptr);
        for (int s = 0; s < 3; s++) begin
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
            idx = (idx == 2) ? 0 : idx + 1;
        end
        return gnt;
    endfunction

    assign w_in_data   = {bus.i_data_pe, bus.i_data_b, bus.i_data_l};
    assign w_in_valid  = {bus.i_valid_pe, bus.i_valid_b, bus.i_valid_l};
    assign w_out_ready = {bus.i_ready_pe, bus.i_ready_t, bus.i_ready_r};

    // Dimension-ordered route: fix X first, then Y, then deliver locally.
    always_comb begin
        w_req = '0;
        for (int k = 0; k < 3; k++) begin
            if (w_in_valid[k]) begin
                if (w_in_data[k][x_size-1:0] != LP_X)
                    w_req[0][k] = 1'b1;
                else if (w_in_data[k][x_size+y_size-1:x_size] != LP_Y)
                    w_req[1][k] = 1'b1;
                else
                    w_req[2][k] = 1'b1;
            end
        end
    end

    // Per-output grant, load mux and next pointer; nothing is granted while in reset.
    always_comb begin
        w_gnt       = '0;
        w_free      = '0;
        w_load_data = r_data;
        w_ptr_nxt   = r_ptr;
        w_in_ready  = '0;
        for (int o = 0; o < 3; o++) begin
            w_free[o] = !r_valid[o] || w_out_ready[o];
            if (rstn && w_free[o])
                w_gnt[o] = rr_pick(w_req[o], r_ptr[o]);
            for (int k = 0; k < 3; k++) begin
                if (w_gnt[o][k]) begin
                    w_load_data[o] = w_in_data[k];
                    w_ptr_nxt[o]   = (k == 2) ? 2'd0 : 2'(k + 1);
                    w_in_ready[k]  = 1'b1;
                end
            end
        end
    end

    // Output registers and pointers: load on grant, drain when consumed, hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '0;
            r_data  <= '0;
            r_ptr   <= '0;
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (|w_gnt[o]) begin
                    r_valid[o] <= 1'b1;
                    r_data[o]  <= w_load_data[o];
                end else if (w_out_ready[o]) begin
                    r_valid[o] <= 1'b0;
                end
                r_ptr[o] <= w_ptr_nxt[o];
            end
        end
    end

    assign bus.o_ready_l  = w_in_ready[0];
    assign bus.o_ready_b  = w_in_ready[1];
    assign bus.o_ready_pe = w_in_ready[2];
    assign bus.o_valid_r  = r_valid[0];
    assign bus.o_valid_t  = r_valid[1];
    assign bus.o_valid_pe = r_valid[2];
    assign bus.o_data_r   = r_data[0];
    assign bus.o_data_t   = r_data[1];
    assign bus.o_data_pe  = r_data[2];

endmodule

// File: tb/tb_noc_switch_arbiter.sv
// Bench for noc_switch_arbiter at node (1,2) of a 4x4 torus, 16-bit payload.
module tb_noc_switch_arbiter;
    localparam int DW = 16;
    localparam int XS = 2;
    localparam int YS = 2;
    localparam int TW = XS + YS + DW;
    localparam int XC = 1;
    localparam int YC = 2;

    typedef logic [2:0][TW-1:0] flit3_t;

    typedef struct {
        logic [2:0] vld;
        flit3_t     d;
        logic [2:0] rdy;
        logic [2:0] e_rdy;
        logic [2:0] e_vld;
        flit3_t     e_d;
    } vec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    noc_switch_arbiter_if #(.total_width(TW)) bus();

    noc_switch_arbiter #(
        .x_coord(XC), .y_coord(YC), .X(4), .Y(4),
        .data_width(DW), .x_size(XS), .y_size(YS)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] mk(input logic [15:0] p, input int dx, input int dy);
        return {p, 2'(dy), 2'(dx)};
    endfunction

    function automatic vec_t mkv(input logic [2:0] vld, input logic [TW-1:0] dl, db, dp,
                                 input logic [2:0] rdy, er, ev,
                                 input logic [TW-1:0] orr, ot, op);
        vec_t t;
        t.vld = vld; t.d[0] = dl; t.d[1] = db; t.d[2] = dp;
        t.rdy = rdy; t.e_rdy = er; t.e_vld = ev;
        t.e_d[0] = orr; t.e_d[1] = ot; t.e_d[2] = op;
        return t;
    endfunction

    task automatic drive(input logic [2:0] v, input flit3_t d, input logic [2:0] r);
        bus.i_valid_l  = v[0]; bus.i_valid_b = v[1]; bus.i_valid_pe = v[2];
        bus.i_data_l   = d[0]; bus.i_data_b  = d[1]; bus.i_data_pe  = d[2];
        bus.i_ready_r  = r[0]; bus.i_ready_t = r[1]; bus.i_ready_pe = r[2];
    endtask

    function automatic logic [2:0] ordy();
        return {bus.o_ready_pe, bus.o_ready_b, bus.o_ready_l};
    endfunction
    function automatic logic [2:0] ovld();
        return {bus.o_valid_pe, bus.o_valid_t, bus.o_valid_r};
    endfunction
    function automatic flit3_t odat();
        return {bus.o_data_pe, bus.o_data_t, bus.o_data_r};
    endfunction

    // Reference route: 0=right, 1=top, 2=local PE
    function automatic int route(input logic [TW-1:0] f);
        if (f[1:0] != 2'(XC)) return 0;
        if (f[3:2] != 2'(YC)) return 1;
        return 2;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        drive(3'b000, '0, 3'b000);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[9];
        logic [TW-1:0] Z, A, L1, B1, P1, L2, B2, P2, L3;
        flit3_t q;
        Z  = '0;
        A  = mk(16'hA001, 3, 2);
        L1 = mk(16'h1111, 1, 2); B1 = mk(16'h2222, 0, 0); P1 = mk(16'h3333, 1, 3);
        L2 = mk(16'h4444, 1, 2); B2 = mk(16'h5555, 1, 2); P2 = mk(16'h6666, 1, 2);
        L3 = mk(16'h7777, 1, 2);
        //          vld     l   b   pe   rdy     e_rdy   e_vld   r   t   pe
        vt[0] = mkv(3'b100, Z,  Z,  A,  3'b111, 3'b100, 3'b001, A,  Z,  Z);
        vt[1] = mkv(3'b000, Z,  Z,  Z,  3'b111, 3'b000, 3'b000, A,  Z,  Z);
        vt[2] = mkv(3'b111, L1, B1, P1, 3'b111, 3'b111, 3'b111, B1, P1, L1);
        vt[3] = mkv(3'b111, L2, B2, P2, 3'b111, 3'b010, 3'b100, B1, P1, B2);
        vt[4] = mkv(3'b101, L2, Z,  P2, 3'b111, 3'b100, 3'b100, B1, P1, P2);
        vt[5] = mkv(3'b001, L2, Z,  Z,  3'b111, 3'b001, 3'b100, B1, P1, L2);
        vt[6] = mkv(3'b000, Z,  Z,  Z,  3'b000, 3'b000, 3'b100, B1, P1, L2);
        vt[7] = mkv(3'b001, L3, Z,  Z,  3'b000, 3'b000, 3'b100, B1, P1, L2);
        vt[8] = mkv(3'b001, L3, Z,  Z,  3'b100, 3'b001, 3'b100, B1, P1, L3);

        // Reset state, with valids presented during reset
        rstn = 1'b0;
        q[0] = L1; q[1] = B1; q[2] = P1;
        drive(3'b111, q, 3'b111);
        #12;
        chk("reset_ready", 20'(ordy()), 20'(3'b000));
        chk("reset_valid", 20'(ovld()), 20'(3'b000));
        chk("reset_data_r", bus.o_data_r, '0);
        do_reset();

        // Table vectors
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].vld, vt[i].d, vt[i].rdy);
            #1;
            chk($sformatf("vec%0d_ready", i), 20'(ordy()), 20'(vt[i].e_rdy));
            tick();
            chk($sformatf("vec%0d_valid", i), 20'(ovld()), 20'(vt[i].e_vld));
            for (int o = 0; o < 3; o++)
                chk($sformatf("vec%0d_data%0d", i, o), odat()[o], vt[i].e_d[o]);
        end

        // Three local flits held valid: grants l, b, pe in order
        begin
            logic [2:0] pend;
            do_reset();
            q[0] = mk(16'hC000, 1, 2); q[1] = mk(16'hC001, 1, 2); q[2] = mk(16'hC002, 1, 2);
            pend = 3'b111;
            for (int c = 0; c < 3; c++) begin
                drive(pend, q, 3'b111);
                #1;
                chk($sformatf("local%0d_ready", c), 20'(ordy()), 20'(3'b001 << c));
                tick();
                chk($sformatf("local%0d_vld", c), 20'(bus.o_valid_pe), 20'(1));
                chk($sformatf("local%0d_data", c), bus.o_data_pe, q[c]);
                pend[c] = 1'b0;
            end
        end

        // Stalled right output, then release with no bubble
        do_reset();
        q = '0;
        q[0] = mk(16'hD001, 3, 0);
        drive(3'b001, q, 3'b111);
        #1 chk("stall_first_ready", 20'(ordy()), 20'(3'b001));
        tick();
        chk("stall_first_vld", 20'(bus.o_valid_r), 20'(1));
        q[0] = mk(16'hD002, 3, 0);
        for (int c = 0; c < 5; c++) begin
            drive(3'b001, q, 3'b110);
            #1 chk($sformatf("stall%0d_ready", c), 20'(ordy()), 20'(3'b000));
            tick();
            chk($sformatf("stall%0d_data", c), bus.o_data_r, mk(16'hD001, 3, 0));
            chk($sformatf("stall%0d_vld", c), 20'(bus.o_valid_r), 20'(1));
        end
        drive(3'b001, q, 3'b111);
        #1 chk("release_ready", 20'(ordy()), 20'(3'b001));
        tick();
        chk("release_vld", 20'(bus.o_valid_r), 20'(1));
        chk("release_data", bus.o_data_r, mk(16'hD002, 3, 0));

        // l and pe contend for right for 20 cycles: strict alternation
        begin
            int nl, np;
            logic [TW-1:0] exp_d;
            do_reset();
            nl = 0; np = 0;
            for (int c = 0; c < 20; c++) begin
                q = '0;
                q[0] = mk(16'hE000 + 16'(nl), 0, 0);
                q[2] = mk(16'hF000 + 16'(np), 3, 3);
                drive(3'b101, q, 3'b111);
                #1;
                chk($sformatf("rr%0d_ready", c), 20'(ordy()), 20'((c % 2 == 0) ? 3'b001 : 3'b100));
                exp_d = (c % 2 == 0) ? q[0] : q[2];
                if (c % 2 == 0) nl++; else np++;
                tick();
                chk($sformatf("rr%0d_data", c), bus.o_data_r, exp_d);
            end
        end

        // Async reset while all outputs are full and stalled
        do_reset();
        q[0] = L1; q[1] = B1; q[2] = P1;
        drive(3'b111, q, 3'b111);
        tick();
        drive(3'b000, '0, 3'b000);
        tick();
        #3 rstn = 1'b0;
        #1;
        chk("arst_valid", 20'(ovld()), 20'(3'b000));
        chk("arst_data_r", bus.o_data_r, '0);
        chk("arst_data_t", bus.o_data_t, '0);
        chk("arst_data_pe", bus.o_data_pe, '0);
        @(posedge clk);
        #1 rstn = 1'b1;
        q[0] = mk(16'hB000, 1, 2); q[1] = mk(16'hB001, 1, 2); q[2] = mk(16'hB002, 2, 2);
        drive(3'b111, q, 3'b111);
        #1 chk("post_rst_ready", 20'(ordy()), 20'(3'b101));
        tick();
        chk("post_rst_valid", 20'(ovld()), 20'(3'b101));
        chk("post_rst_pe", bus.o_data_pe, q[0]);
        chk("post_rst_r", bus.o_data_r, q[2]);

        // Randomized traffic against the reference model
        begin
            logic          m_v [3];
            logic [TW-1:0] m_d [3];
            int            m_p [3];
            int            win [3];
            logic [2:0]    v, r, acc, mv;
            flit3_t        d;
            do_reset();
            for (int o = 0; o < 3; o++) begin m_v[o] = 1'b0; m_d[o] = '0; m_p[o] = 0; end
            v = '0; acc = '0; d = '0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                for (int k = 0; k < 3; k++) begin
                    if (!v[k] || acc[k]) begin
                        v[k] = ($urandom_range(0, 9) < 6);
                        d[k] = {16'($urandom), 4'($urandom)};
                    end
                end
                r[0] = ($urandom_range(0, 3) != 0);
                r[1] = ($urandom_range(0, 3) != 0);
                r[2] = ($urandom_range(0, 4) != 0);
                acc = '0;
                for (int o = 0; o < 3; o++) begin
                    win[o] = -1;
                    if (!m_v[o] || r[o]) begin
                        for (int s = 0; s < 3; s++) begin
                            int k;
                            k = (m_p[o] + s) % 3;
                            if (win[o] < 0 && v[k] && route(d[k]) == o) win[o] = k;
                        end
                    end
                    if (win[o] >= 0) acc[win[o]] = 1'b1;
                end
                drive(v, d, r);
                #1 chk($sformatf("rand%0d_ready", cyc), 20'(ordy()), 20'(acc));
                for (int o = 0; o < 3; o++) begin
                    if (win[o] >= 0) begin
                        m_v[o] = 1'b1;
                        m_d[o] = d[win[o]];
                        m_p[o] = (win[o] + 1) % 3;
                    end else if (r[o]) begin
                        m_v[o] = 1'b0;
                    end
                end
                tick();
                mv = {m_v[2], m_v[1], m_v[0]};
                chk($sformatf("rand%0d_valid", cyc), 20'(ovld()), 20'(mv));
                for (int o = 0; o < 3; o++)
                    chk($sformatf("rand%0d_data%0d", cyc, o), odat()[o], m_d[o]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
